// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the shift-register command sequencer.
package shift_ctrl_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_SHL  = 2'b10,
    OP_SHR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;
endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; push/pop are self-guarded against full/empty.
module cmd_fifo #(
  parameter  int DEPTH = 4,
  parameter  int EW    = 10,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [EW-1:0] wr_data,
  output logic [EW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [DEPTH-1:0][EW-1:0] mem;
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic                     do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end
endmodule

// File: rtl/shift_reg_ctrl.sv
// Command sequencer: queues LOAD/SHL/SHR commands and expands them into
// single-cycle strobes for a shift register, pulsing done per command.
module shift_reg_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [WIDTH-1:0]         cmd_data,
  input  logic [CNT_W-1:0]         cmd_cnt,
  output logic                     ld,
  output logic                     sl,
  output logic                     sr,
  output logic [WIDTH-1:0]         d_out,
  output logic [CNT_W-1:0]         s_cnt_out,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int EW = 2 + WIDTH + CNT_W;

  logic             push, pop, full, empty, shift_act;
  logic [EW-1:0]    rd_entry;
  state_e           state, state_nx;
  op_e              op_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] cnt_r, remaining;

  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == ST_IDLE) && !empty;

  cmd_fifo #(.DEPTH(DEPTH), .EW(EW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data ({cmd_op, cmd_data, cmd_cnt}),
    .rd_data (rd_entry),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // remaining==0 covers both a zero-count shift and the idle datapath.
  assign shift_act = (state == ST_EXEC) && (op_r == OP_SHL || op_r == OP_SHR)
                     && (remaining != '0);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (!empty) state_nx = ST_EXEC;
      ST_EXEC: state_nx = (shift_act && remaining != CNT_W'(1)) ? ST_EXEC : ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_r      <= OP_NOP;
      data_r    <= '0;
      cnt_r     <= '0;
      remaining <= '0;
    end else begin
      state <= state_nx;
      if (pop) begin
        op_r      <= op_e'(rd_entry[EW-1 -: 2]);
        data_r    <= rd_entry[CNT_W +: WIDTH];
        cnt_r     <= rd_entry[CNT_W-1:0];
        remaining <= rd_entry[CNT_W-1:0];
      end else if (shift_act) begin
        remaining <= remaining - 1'b1;
      end
    end
  end

  // Moore outputs: everything decodes from registered state, so rst drops them at once.
  assign ld        = (state == ST_EXEC) && (op_r == OP_LOAD);
  assign sl        = shift_act && (op_r == OP_SHL);
  assign sr        = shift_act && (op_r == OP_SHR);
  assign d_out     = ld ? data_r : '0;
  assign s_cnt_out = shift_act ? CNT_W'(1) : '0;
  assign done      = (state == ST_DONE);
  assign busy      = (state != ST_IDLE) || (level != '0);
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Scoreboard bench: accepted commands expand into expected strobe/done events,
// and a negedge monitor matches every DUT event against that queue.
module tb_shift_reg_ctrl;
  import shift_ctrl_pkg::*;
  localparam int WIDTH = 4, CNT_W = 4, DEPTH = 4, LW = $clog2(DEPTH) + 1;

  logic             clk = 1'b0, rst = 1'b1;
  logic             cmd_valid, cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data, d_out;
  logic [CNT_W-1:0] cmd_cnt, s_cnt_out;
  logic             ld, sl, sr, busy, done;
  logic [LW-1:0]    level;

  shift_reg_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
    .ld(ld), .sl(sl), .sr(sr), .d_out(d_out), .s_cnt_out(s_cnt_out),
    .busy(busy), .done(done), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               ld, sl, sr, done, contig;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] s;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks = 0, failures = 0, cyc = 0, last_ev = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: a command is a list of per-cycle events ending in done.
  task automatic model_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data,
                           input logic [CNT_W-1:0] cnt);
    ev_t e;
    bit  strobed = 0;
    if (op == OP_LOAD) begin
      e = '{default: 0}; e.ld = 1; e.d = data;
      exp_q.push_back(e); strobed = 1;
    end else if (op == OP_SHL || op == OP_SHR) begin
      for (int i = 0; i < int'(cnt); i++) begin
        e = '{default: 0}; e.sl = (op == OP_SHL); e.sr = (op == OP_SHR);
        e.s = 1; e.contig = (i != 0);
        exp_q.push_back(e); strobed = 1;
      end
    end
    e = '{default: 0}; e.done = 1; e.contig = strobed;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] data,
                      input logic [CNT_W-1:0] cnt, output bit acc);
    cmd_valid = 1; cmd_op = op; cmd_data = data; cmd_cnt = cnt;
    acc = cmd_ready;
    if (acc) model_cmd(op, data, cnt);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0; cmd_op = 2'($urandom); cmd_data = WIDTH'($urandom); cmd_cnt = CNT_W'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    chk("idle_timeout", busy, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("one_strobe", 32'(ld) + 32'(sl) + 32'(sr) <= 1, 1);
      if (!ld) chk("d_out_quiet", d_out, 0);
      if (!(sl || sr)) chk("s_cnt_quiet", s_cnt_out, 0);
      if (ld || sl || sr || done) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_event actual=ld%0b sl%0b sr%0b done%0b required=none", ld, sl, sr, done);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ev_ld", ld, mon_e.ld);
          chk("ev_sl", sl, mon_e.sl);
          chk("ev_sr", sr, mon_e.sr);
          chk("ev_done", done, mon_e.done);
          if (ld) chk("ev_d_out", d_out, mon_e.d);
          if (sl || sr) chk("ev_s_cnt", s_cnt_out, mon_e.s);
          if (mon_e.contig) chk("ev_consecutive", cyc - last_ev, 1);
          else              chk("ev_gap_min2", (cyc - last_ev) >= 2, 1);
        end
        last_ev = cyc;
      end
    end
  end

  task automatic load_latency(input logic [WIDTH-1:0] val, input string tag);
    bit acc;
    send(OP_LOAD, val, CNT_W'($urandom), acc);
    chk({tag, "_acc"}, acc, 1);
    chk({tag, "_no_ld_yet"}, ld, 0);
    chk({tag, "_level1"}, level, 1);
    chk({tag, "_busy"}, busy, 1);
    @(negedge clk);
    chk({tag, "_ld"}, ld, 1);
    chk({tag, "_d_out"}, d_out, val);
    chk({tag, "_level0"}, level, 0);
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_busy_fall"}, busy, 0);
  endtask

  initial begin
    bit acc;
    int n;
    cmd_valid = 0; cmd_op = 0; cmd_data = 0; cmd_cnt = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {ld, sl, sr, done}, 0);
    chk("rst_data", {d_out, s_cnt_out}, 0);
    rst = 0;
    @(negedge clk);

    load_latency(4'b1010, "load");

    send(OP_SHL, 0, 3, acc);  wait_idle(100);
    send(OP_SHR, 0, 15, acc); wait_idle(100);
    send(OP_SHL, 0, 0, acc);
    send(OP_NOP, 4'hF, 7, acc);
    wait_idle(100);

    // Fill the FIFO behind a running SHR 5.
    send(OP_SHR, 0, 5, acc);
    send(OP_LOAD, 4'h3, 0, acc);
    send(OP_SHL, 0, 2, acc);
    send(OP_SHR, 0, 1, acc);
    send(OP_NOP, 0, 0, acc);
    chk("full_level", level, 4);
    chk("full_ready", cmd_ready, 0);
    send(OP_LOAD, 4'h9, 0, acc);
    chk("fifth_rejected", acc, 0);
    chk("fifth_level", level, 4);
    n = 0;
    while (level == 4 && n < 50) begin @(negedge clk); n++; end
    chk("after_pop_level", level, 3);
    chk("after_pop_ready", cmd_ready, 1);
    wait_idle(200);

    // Push coincident with pop at level 2.
    send(OP_SHL, 0, 3, acc);
    send(OP_LOAD, 4'h5, 0, acc);
    send(OP_SHR, 0, 2, acc);
    n = 0;
    while (!done && n < 50) begin @(negedge clk); n++; end
    chk("pp_saw_done", done, 1);
    @(negedge clk);
    chk("pp_pre_level", level, 2);
    send(OP_LOAD, 4'hC, 0, acc);
    chk("pp_acc", acc, 1);
    chk("pp_level", level, 2);
    wait_idle(200);

    // Randomized command stream.
    repeat (40) begin
      logic [CNT_W-1:0] c;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      c = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(0, 15)) : CNT_W'($urandom_range(0, 3));
      send(2'($urandom), WIDTH'($urandom), c, acc);
    end
    wait_idle(2000);

    // Reset in the middle of a shift aborts it without done.
    send(OP_SHL, 0, 5, acc);
    n = 0;
    while (n < 2 && cyc < 90000) begin @(negedge clk); if (sl) n++; end
    chk("abort_two_pulses", n, 2);
    #1 rst = 1; exp_q.delete();
    #1;
    chk("abort_sl", sl, 0);
    chk("abort_level", level, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    rst = 0; last_ev = -100;
    repeat (3) begin @(negedge clk); chk("abort_no_done", done, 0); end
    load_latency(4'b0110, "reload");

    wait_idle(100);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
Command sequencer that drives the 4-bit shift register's control inputs (ld, sl, sr, d_in, s_cnt) from a queued command stream. It accepts LOAD, shift-left and shift-right commands over a valid/ready handshake and buffers them in a small FIFO. It expands each multi-step shift into single-step pulses, one per cycle, and reports completion. It sits between a host/test sequencer and the shift register instance.

Parameters:
WIDTH, 4, data width of the shift register (d_in/q)
CNT_W, 4, width of the shift-count field
DEPTH, 4, command FIFO depth (power of 2, >=2)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept (not full)
cmd_op  in  2  00 NOP, 01 LOAD, 10 SHL, 11 SHR
cmd_data  in  WIDTH  load value (LOAD only)
cmd_cnt  in  CNT_W  number of single-bit shifts (SHL/SHR only)
ld  out  1  load strobe to shift register
sl  out  1  shift-left strobe
sr  out  1  shift-right strobe
d_out  out  WIDTH  drives shift register d_in
s_cnt_out  out  CNT_W  drives shift register s_cnt
busy  out  1  FSM not in IDLE or FIFO non-empty
done  out  1  one-cycle pulse per completed command
level  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, any state): FIFO flushed, level=0, state IDLE, remaining=0; all outputs 0 except cmd_ready=1.
- Handshake: push on the rising edge when cmd_valid && cmd_ready. cmd_ready = (level != DEPTH), derived from registered level. Payload ignored when not accepted.
- Push and pop in the same cycle: level unchanged, order preserved. A full FIFO deasserts ready, so no push occurs that cycle even if a pop happens.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: if FIFO non-empty, pop head into op_r/data_r/cnt_r; remaining := cnt_r; go to EXEC.
  - EXEC, LOAD: ld=1 and d_out=data_r for exactly one cycle, then DONE.
  - EXEC, SHL/SHR: sl (or sr)=1 and s_cnt_out=1 each cycle; remaining decrements per pulse. Leave for DONE after the pulse where remaining==1, so exactly cnt pulses on consecutive cycles.
  - EXEC, cnt==0 or NOP: no strobe; go directly to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Outputs are Moore, decoded from registered state. At most one of ld/sl/sr is high in any cycle. d_out=0 and s_cnt_out=0 whenever the matching strobe is low.
- Latency: command accepted at edge t into an empty idle block -> first strobe in the cycle after edge t+1 -> done in the cycle after the last strobe.
- Per-command overhead: 2 idle cycles (IDLE pop, DONE). Command execution is strictly in order.
- busy = (state != IDLE) || (level != 0).
- cnt_r widths: remaining is CNT_W bits; cnt = 2^CNT_W-1 (15) is legal and yields 15 pulses. No wrap.
- Reset during EXEC aborts the command with no done pulse; strobes drop asynchronously with rst.

Decomposition:
- Package shift_ctrl_pkg: op encodings (OP_NOP/OP_LOAD/OP_SHL/OP_SHR), FSM state encoding, default WIDTH/CNT_W.
- Sub-module cmd_fifo: synchronous FIFO, DEPTH entries of {op, data, cnt}, with push/pop/full/empty/level. The async-reset register array and pointers live there. Controller FSM stays in shift_reg_ctrl.

Test Plan:
- Reset, then LOAD data=1010 -> ld high exactly 1 cycle with d_out=1010, sl=sr=0; done pulses the following cycle; level returns 0; busy falls after done.
- SHL cnt=3 -> sl high 3 consecutive cycles with s_cnt_out=0001, sr=ld=0; done the next cycle. Repeat SHR cnt=15 -> 15 sr pulses.
- SHL cnt=0, then NOP -> no strobe ever asserted; two done pulses, each separated by the IDLE cycle.
- While an SHR cnt=5 executes, push 4 commands back-to-back -> level reaches 4 and cmd_ready=0. A 5th cmd_valid is not accepted. Commands then execute in push order; cmd_ready re-asserts the cycle after the first pop.
- Push and pop in the same cycle at level=2 -> level stays 2; popped entry is the oldest.
- Assert rst after 2 of 5 sl pulses -> strobes 0 immediately, level=0, no done. After release, LOAD 0110 executes with the normal latency.
